pc_gen_unit: RTL and testbench

//  Parametrised next-PC generator for the IF stage; successor to the 4-way PC mux register.

---
 rtl/pc_gen_if.sv | 32 +++
 rtl/pc_gen_unit.sv | 161 ++++++++++++++++
 tb/tb_pc_gen_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch-side bundle between the redirect sources (trap, EX, BTB), the next-PC generator
// and the I-cache. The slave side is the PC generator itself.
interface pc_gen_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic                stall_i;
  logic                trap_vld_i;
  logic [PC_WIDTH-1:0] trap_pc_i;
  logic                ex_redir_i;
  logic [PC_WIDTH-1:0] ex_pc_i;
  logic                btb_hit_i;
  logic [PC_WIDTH-1:0] btb_pc_i;
  logic                btb_call_i;
  logic                btb_ret_i;
  logic [PC_WIDTH-1:0] pc_o;
  logic                pc_vld_o;
  logic                pend_o;
  logic                ras_empty_o;
  logic                misalign_o;

  modport master (
    output stall_i, trap_vld_i, trap_pc_i, ex_redir_i, ex_pc_i,
           btb_hit_i, btb_pc_i, btb_call_i, btb_ret_i,
    input  pc_o, pc_vld_o, pend_o, ras_empty_o, misalign_o
  );

  modport slave (
    input  stall_i, trap_vld_i, trap_pc_i, ex_redir_i, ex_pc_i,
           btb_hit_i, btb_pc_i, btb_call_i, btb_ret_i,
    output pc_o, pc_vld_o, pend_o, ras_empty_o, misalign_o
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Next-PC generator for the IF stage: fixed-priority redirect arbitration, stall-time
// redirect buffering and a circular return address stack for call/return prediction.
module pc_gen_unit #(
  parameter int unsigned         PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned         RAS_DEPTH    = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  pc_gen_if.slave bus
);

  localparam int unsigned      PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned      CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HOLD      = 2'd1,
    HOLD_PEND = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic                vld_q, vld_d;
  logic [PC_WIDTH-1:0] buf_pc_q, buf_pc_d;
  logic                buf_trap_q, buf_trap_d;

  logic [PC_WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]    ras_ptr_q;
  logic [PTR_W-1:0]    ras_top_idx;
  logic [CNT_W-1:0]    ras_cnt_q;
  logic [PC_WIDTH-1:0] ras_top;
  logic                ras_empty;
  logic                ras_push;
  logic                ras_pop;
  logic                ras_clr;

  // Count saturates at the depth: a push on a full stack overwrites the oldest slot.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  assign pc_inc      = pc_q + PC_WIDTH'(4);
  assign ras_empty   = (ras_cnt_q == '0);
  assign ras_top_idx = ras_ptr_q - PTR_W'(1);
  assign ras_top     = ras_mem_q[ras_top_idx];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    vld_d      = 1'b1;
    buf_pc_d   = buf_pc_q;
    buf_trap_d = buf_trap_q;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    ras_clr    = 1'b0;

    if (bus.stall_i) begin
      // PC and RAS frozen; only the redirect buffer can change.
      unique case (state_q)
        RUN, HOLD: begin
          if (bus.trap_vld_i) begin
            buf_pc_d   = bus.trap_pc_i;
            buf_trap_d = 1'b1;
            state_d    = HOLD_PEND;
          end else if (bus.ex_redir_i) begin
            buf_pc_d   = bus.ex_pc_i;
            buf_trap_d = 1'b0;
            state_d    = HOLD_PEND;
          end else begin
            state_d    = HOLD;
          end
        end
        HOLD_PEND: begin
          // A buffered trap outranks any later EX redirect.
          if (bus.trap_vld_i) begin
            buf_pc_d   = bus.trap_pc_i;
            buf_trap_d = 1'b1;
          end else if (bus.ex_redir_i && !buf_trap_q) begin
            buf_pc_d   = bus.ex_pc_i;
          end
        end
        default: state_d = RUN;
      endcase
    end else begin
      state_d = RUN;
      if (bus.trap_vld_i) begin
        pc_d    = bus.trap_pc_i;
        ras_clr = 1'b1;
      end else if (bus.ex_redir_i) begin
        pc_d    = bus.ex_pc_i;
      end else if (state_q == HOLD_PEND) begin
        pc_d    = buf_pc_q;
        ras_clr = buf_trap_q;
      end else if (!vld_q) begin
        // First cycle out of reset: the reset vector itself is the first fetch address.
        pc_d    = pc_q;
      end else if (bus.btb_hit_i) begin
        if (bus.btb_call_i && !bus.btb_ret_i) begin
          pc_d     = bus.btb_pc_i;
          ras_push = 1'b1;
        end else if (bus.btb_ret_i && !bus.btb_call_i && !ras_empty) begin
          pc_d     = ras_top;
          ras_pop  = 1'b1;
        end else begin
          pc_d     = bus.btb_pc_i;
        end
      end else begin
        pc_d    = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_VECTOR;
      vld_q      <= 1'b0;
      buf_trap_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      vld_q      <= vld_d;
      buf_trap_q <= buf_trap_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_pc_q <= buf_pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else if (ras_clr) begin
      ras_cnt_q <= '0;
    end else if (ras_push) begin
      ras_ptr_q <= ras_ptr_q + PTR_W'(1);
      ras_cnt_q <= cnt_sat_inc(ras_cnt_q);
    end else if (ras_pop) begin
      ras_ptr_q <= ras_top_idx;
      ras_cnt_q <= ras_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push) begin
      ras_mem_q[ras_ptr_q] <= pc_inc;
    end
  end

  assign bus.pc_o        = pc_q;
  assign bus.pc_vld_o    = vld_q;
  assign bus.pend_o      = (state_q == HOLD_PEND);
  assign bus.ras_empty_o = ras_empty;
  assign bus.misalign_o  = |pc_q[1:0];

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: directed scenarios plus random traffic, checked against
// a queue-based behavioural model of the next-PC rules.
module tb_pc_gen_unit;
  localparam int unsigned W     = 32;
  localparam logic [31:0] RV    = 32'h100;
  localparam int          DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pc_gen_if #(.PC_WIDTH(W)) bus ();

  pc_gen_unit #(.PC_WIDTH(W), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        vld;
    logic        pend;
    logic        empty;
    logic        mis;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model state: stack as a plain queue, stall tracked as "redirect waiting".
  logic [31:0] m_pc;
  logic [31:0] m_buf;
  bit          m_vld;
  bit          m_pend;
  bit          m_buf_trap;
  logic [31:0] m_ras[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, required 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] nxt;
    exp_t        e;
    nxt = m_pc;
    if (bus.stall_i) begin
      if (bus.trap_vld_i) begin
        m_pend = 1; m_buf_trap = 1; m_buf = bus.trap_pc_i;
      end else if (bus.ex_redir_i && !(m_pend && m_buf_trap)) begin
        m_pend = 1; m_buf_trap = 0; m_buf = bus.ex_pc_i;
      end
    end else begin
      if (bus.trap_vld_i) begin
        nxt = bus.trap_pc_i;
        m_ras.delete();
      end else if (bus.ex_redir_i) begin
        nxt = bus.ex_pc_i;
      end else if (m_pend) begin
        nxt = m_buf;
        if (m_buf_trap) m_ras.delete();
      end else if (!m_vld) begin
        nxt = m_pc;
      end else if (bus.btb_hit_i) begin
        if (bus.btb_call_i && !bus.btb_ret_i) begin
          nxt = bus.btb_pc_i;
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (bus.btb_ret_i && !bus.btb_call_i && m_ras.size() > 0) begin
          nxt = m_ras.pop_back();
        end else begin
          nxt = bus.btb_pc_i;
        end
      end else begin
        nxt = m_pc + 32'd4;
      end
      m_pend = 0;
    end
    m_pc  = nxt;
    m_vld = 1;
    e.pc    = m_pc;
    e.vld   = 1'b1;
    e.pend  = m_pend;
    e.empty = (m_ras.size() == 0);
    e.mis   = (m_pc[1:0] != 2'b00);
    sb_q.push_back(e);
  endtask

  // Called at a falling edge: apply inputs for the next rising edge, then wait one cycle.
  task automatic drive(input bit st, input bit tv, input logic [31:0] tpc,
                       input bit ev, input logic [31:0] epc, input bit hit,
                       input logic [31:0] bpc, input bit call, input bit ret);
    bus.stall_i    = st;
    bus.trap_vld_i = tv;
    bus.trap_pc_i  = tpc;
    bus.ex_redir_i = ev;
    bus.ex_pc_i    = epc;
    bus.btb_hit_i  = hit;
    bus.btb_pc_i   = bpc;
    bus.btb_call_i = call;
    bus.btb_ret_i  = ret;
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ex_to(input logic [31:0] a);
    drive(0, 0, 0, 1, a, 0, 0, 0, 0);
  endtask

  task automatic trap_to(input logic [31:0] a);
    drive(0, 1, a, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.stall_i = 0; bus.trap_vld_i = 0; bus.trap_pc_i = 0; bus.ex_redir_i = 0;
    bus.ex_pc_i = 0; bus.btb_hit_i = 0; bus.btb_pc_i = 0; bus.btb_call_i = 0;
    bus.btb_ret_i = 0;
    sb_q.delete();
    m_pc = RV; m_vld = 0; m_pend = 0; m_buf_trap = 0; m_buf = 0;
    m_ras.delete();
    @(negedge clk);
    chk("rst_pc", bus.pc_o, RV);
    chk("rst_vld", 32'(bus.pc_vld_o), 0);
    chk("rst_pend", 32'(bus.pend_o), 0);
    chk("rst_empty", 32'(bus.ras_empty_o), 1);
    chk("rst_mis", 32'(bus.misalign_o), 0);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] a;
    a = $urandom() & 32'hFFFF_FFFC;
    if ($urandom_range(15) == 0) a[1:0] = 2'($urandom_range(3));
    return a;
  endfunction

  always @(posedge clk) begin
    #2;
    if (rst_n && sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("sb_pc", bus.pc_o, e.pc);
      chk("sb_vld", 32'(bus.pc_vld_o), 32'(e.vld));
      chk("sb_pend", 32'(bus.pend_o), 32'(e.pend));
      chk("sb_empty", 32'(bus.ras_empty_o), 32'(e.empty));
      chk("sb_mis", 32'(bus.misalign_o), 32'(e.mis));
    end
  end

  initial begin
    do_reset();

    // Free-running after reset.
    idle(); chk("t1_pc0", bus.pc_o, 32'h100); chk("t1_vld", 32'(bus.pc_vld_o), 1);
    idle(); chk("t1_pc1", bus.pc_o, 32'h104);
    idle(); chk("t1_pc2", bus.pc_o, 32'h108);

    // EX redirect in the second stall cycle is buffered, then applied on release.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 32'h400, 0, 0, 0, 0);
    chk("t2_pend", 32'(bus.pend_o), 1); chk("t2_hold", bus.pc_o, 32'h108);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(); chk("t2_pc", bus.pc_o, 32'h400); chk("t2_pend0", 32'(bus.pend_o), 0);

    // Buffered EX then trap: trap wins.
    drive(0, 0, 0, 0, 0, 1, 32'h40, 1, 0);
    drive(1, 0, 0, 1, 32'h400, 0, 0, 0, 0);
    drive(1, 1, 32'h800, 0, 0, 0, 0, 0, 0);
    idle(); chk("t3a_pc", bus.pc_o, 32'h800); chk("t3a_empty", 32'(bus.ras_empty_o), 1);
    // Buffered trap then EX: EX may not displace the trap.
    drive(0, 0, 0, 0, 0, 1, 32'h40, 1, 0);
    chk("t3b_full", 32'(bus.ras_empty_o), 0);
    drive(1, 1, 32'h800, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 32'h400, 0, 0, 0, 0);
    idle(); chk("t3b_pc", bus.pc_o, 32'h800); chk("t3b_empty", 32'(bus.ras_empty_o), 1);
    // EX replaces a buffered EX.
    drive(1, 0, 0, 1, 32'h400, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 32'h500, 0, 0, 0, 0);
    idle(); chk("t3c_pc", bus.pc_o, 32'h500);

    // Five calls into a four-deep stack, then five returns.
    ex_to(32'h10);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 1, bus.pc_o + 32'd4, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h5000, 0, 1); chk("t4_r0", bus.pc_o, 32'h24);
    drive(0, 0, 0, 0, 0, 1, 32'h5000, 0, 1); chk("t4_r1", bus.pc_o, 32'h20);
    drive(0, 0, 0, 0, 0, 1, 32'h5000, 0, 1); chk("t4_r2", bus.pc_o, 32'h1C);
    drive(0, 0, 0, 0, 0, 1, 32'h5000, 0, 1); chk("t4_r3", bus.pc_o, 32'h18);
    drive(0, 0, 0, 0, 0, 1, 32'h5000, 0, 1); chk("t4_r4", bus.pc_o, 32'h5000);
    chk("t4_empty", 32'(bus.ras_empty_o), 1);

    // Redirects override the BTB path, which then leaves the stack alone.
    drive(0, 1, 32'h900, 0, 0, 1, 32'h40, 1, 0);
    chk("t5_trap", bus.pc_o, 32'h900); chk("t5_empty", 32'(bus.ras_empty_o), 1);
    drive(0, 0, 0, 0, 0, 1, 32'h40, 1, 0);
    drive(0, 0, 0, 1, 32'h300, 1, 32'h60, 1, 0); chk("t5_ex", bus.pc_o, 32'h300);
    drive(0, 0, 0, 0, 0, 1, 32'h700, 0, 1); chk("t5_ret", bus.pc_o, 32'h904);
    drive(0, 0, 0, 0, 0, 1, 32'h700, 0, 1); chk("t5_ret_empty", bus.pc_o, 32'h700);

    // Wraparound and misalignment.
    ex_to(32'hFFFF_FFFC);
    idle(); chk("t6_wrap", bus.pc_o, 32'h0);
    ex_to(32'h402); chk("t6_mis", 32'(bus.misalign_o), 1);

    // Reset in the middle of a buffered stall discards the buffer.
    drive(1, 0, 0, 1, 32'h600, 0, 0, 0, 0);
    chk("t7_pend", 32'(bus.pend_o), 1);
    do_reset();
    idle(); chk("t7_pc", bus.pc_o, RV);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(599) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(3) == 0, $urandom_range(19) == 0, rnd_pc(),
              $urandom_range(9) == 0, rnd_pc(), $urandom_range(9) < 4, rnd_pc(),
              $urandom_range(9) < 3, $urandom_range(9) < 3);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
